// File: rtl/mmm_pkg.sv
// Shared fetch-stage types and constants: XLEN/OFFSET, the branch resolution
// record, and the BTB entry, flush-state and tag helpers used by btb_assoc.
package mmm_pkg;

    localparam int XLEN             = 32;
    localparam int OFFSET           = 2;
    localparam int BTB_WAYS_DEFAULT = 2;
    localparam int BTB_TAG_MAX_W    = XLEN - OFFSET;
    localparam int BTB_TGT_W        = XLEN - OFFSET;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
    } resolution_t;

    // Tag is stored zero-extended to its widest possible width; the upper bits
    // stay constant zero for any real BTB_BITS and fold away in synthesis.
    typedef struct packed {
        logic                     valid;
        logic [BTB_TAG_MAX_W-1:0] tag;
        logic [BTB_TGT_W-1:0]     target;
    } btb_entry_t;

    typedef enum logic {
        BTB_IDLE  = 1'b0,
        BTB_SWEEP = 1'b1
    } btb_fsm_t;

    function automatic logic [BTB_TAG_MAX_W-1:0] btb_tag(input logic [XLEN-1:0] pc,
                                                         input int unsigned set_bits);
        return BTB_TAG_MAX_W'(pc >> (set_bits + OFFSET));
    endfunction

endpackage

// File: rtl/btb_assoc_repl.sv
// btb_repl: per-set replacement state for btb_assoc. Round-robin pointer by
// default; tree pseudo-LRU when BTB_PLRU_EN is defined.
module btb_repl
    import mmm_pkg::*;
#(
    parameter int BTB_BITS = 4,
    parameter int WAYS     = BTB_WAYS_DEFAULT,
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [BTB_BITS-1:0] lkp_set_i,
    input  logic [WAY_W-1:0]    lkp_way_i,
    input  logic                lkp_touch_i,
    input  logic [BTB_BITS-1:0] wr_set_i,
    input  logic [WAY_W-1:0]    wr_way_i,
    input  logic                wr_touch_i,
    input  logic                alloc_i,
    input  logic                clr_set_i,
    input  logic [BTB_BITS-1:0] clr_idx_i,
    input  logic                clr_all_i,
    output logic [WAY_W-1:0]    victim_o
);

    localparam int BTB_ROWS = 1 << BTB_BITS;

`ifdef BTB_PLRU_EN
    localparam int TREE_W = (WAYS > 1) ? WAYS - 1 : 1;
    localparam int LVL    = $clog2(WAYS);

    logic [TREE_W-1:0] tree_q [BTB_ROWS];
    logic [TREE_W-1:0] tree_d [BTB_ROWS];
    logic              unused;

    // Each node bit points towards the less recently used subtree.
    function automatic logic [TREE_W-1:0] plru_touch(input logic [TREE_W-1:0] t,
                                                     input logic [WAY_W-1:0]  way);
        logic [TREE_W-1:0] r;
        int                n;
        logic              dir;
        r = t;
        n = 0;
        for (int l = 0; l < LVL; l++) begin
            dir  = way[LVL-1-l];
            r[n] = ~dir;
            n    = 2 * n + 1 + int'(dir);
        end
        return r;
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [TREE_W-1:0] t);
        int n;
        n = 0;
        for (int l = 0; l < LVL; l++) n = 2 * n + 1 + int'(t[n]);
        return WAY_W'(n - (WAYS - 1));
    endfunction

    always_comb begin
        tree_d = tree_q;
        if (lkp_touch_i) tree_d[lkp_set_i] = plru_touch(tree_d[lkp_set_i], lkp_way_i);
        if (wr_touch_i)  tree_d[wr_set_i]  = plru_touch(tree_d[wr_set_i], wr_way_i);
        if (clr_set_i)   tree_d[clr_idx_i] = '0;
        if (clr_all_i) begin
            for (int r = 0; r < BTB_ROWS; r++) tree_d[r] = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int r = 0; r < BTB_ROWS; r++) tree_q[r] <= '0;
        end else begin
            tree_q <= tree_d;
        end
    end

    assign victim_o = plru_victim(tree_q[wr_set_i]);
    assign unused   = alloc_i;
`else
    logic [WAY_W-1:0] ptr_q [BTB_ROWS];
    logic [WAY_W-1:0] ptr_d [BTB_ROWS];
    logic             unused;

    always_comb begin
        ptr_d = ptr_q;
        if (alloc_i) ptr_d[wr_set_i] = (WAYS > 1) ? ptr_q[wr_set_i] + WAY_W'(1) : '0;
        if (clr_set_i) ptr_d[clr_idx_i] = '0;
        if (clr_all_i) begin
            for (int r = 0; r < BTB_ROWS; r++) ptr_d[r] = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int r = 0; r < BTB_ROWS; r++) ptr_q[r] <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign victim_o = ptr_q[wr_set_i];
    assign unused   = ^{lkp_set_i, lkp_way_i, lkp_touch_i, wr_way_i, wr_touch_i};
`endif

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with combinational lookup and a
// multi-cycle flush sweep. Define BTB_PLRU_EN for tree pseudo-LRU replacement.
//
// state     | meaning
// BTB_IDLE  | lookups and updates accepted, ready_o=1
// BTB_SWEEP | clearing one set per cycle, ready_o=0
module btb_assoc
    import mmm_pkg::*;
#(
    parameter int BTB_BITS = 4,
    parameter int WAYS     = BTB_WAYS_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   flush_i,
    input  logic [XLEN-1:0]        pc_i,
    input  logic                   valid_i,
    input  logic                   del_entry_i,
    input  resolution_t            res_i,
    output logic                   hit_o,
    output logic [XLEN-OFFSET-1:0] target_o,
    output logic                   ready_o
);

    localparam int BTB_ROWS = 1 << BTB_BITS;
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

    btb_entry_t ent_q [BTB_ROWS][WAYS];
    btb_entry_t ent_d [BTB_ROWS][WAYS];
    btb_fsm_t   state_q, state_d;
    logic [BTB_BITS-1:0] cnt_q, cnt_d;
    logic       sweep;

    logic [BTB_BITS-1:0]      lk_idx, wr_idx;
    logic [BTB_TAG_MAX_W-1:0] lk_tag, wr_tag;
    logic [WAYS-1:0]          lk_match;
    logic [WAY_W-1:0]         lk_way, wr_hit_way, inv_way, victim, wr_way;
    logic                     lk_hit, hit, wr_hit, inv_found;
    logic                     do_upd, do_wr, do_del, alloc;
    logic                     unused;

    assign lk_idx = pc_i[BTB_BITS+OFFSET-1:OFFSET];
    assign lk_tag = btb_tag(pc_i, BTB_BITS);
    assign wr_idx = res_i.pc[BTB_BITS+OFFSET-1:OFFSET];
    assign wr_tag = btb_tag(res_i.pc, BTB_BITS);

    always_comb begin
        lk_match = '0;
        lk_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (ent_q[lk_idx][w].valid && ent_q[lk_idx][w].tag == lk_tag) begin
                lk_match[w] = 1'b1;
                lk_way      = WAY_W'(w);
            end
        end
    end

    assign lk_hit   = ($countones(lk_match) == 1);
    assign hit      = ready_o && lk_hit;
    assign hit_o    = hit;
    assign target_o = lk_hit ? ent_q[lk_idx][lk_way].target : ent_q[lk_idx][0].target;

    // Update side: matching way first, then lowest free way, then the victim.
    always_comb begin
        wr_hit     = 1'b0;
        wr_hit_way = '0;
        inv_found  = 1'b0;
        inv_way    = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (ent_q[wr_idx][w].valid && ent_q[wr_idx][w].tag == wr_tag) begin
                wr_hit     = 1'b1;
                wr_hit_way = WAY_W'(w);
            end
            if (!ent_q[wr_idx][w].valid) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign do_upd = valid_i && ready_o && !flush_i;
    assign do_wr  = do_upd && !del_entry_i;
    assign do_del = do_upd && del_entry_i;
    assign alloc  = do_wr && !wr_hit && !inv_found;
    assign wr_way = wr_hit ? wr_hit_way : (inv_found ? inv_way : victim);

    always_comb begin
        ent_d = ent_q;
        if (sweep) begin
            for (int w = 0; w < WAYS; w++) ent_d[cnt_q][w] = '0;
        end else if (do_wr) begin
            ent_d[wr_idx][wr_way].valid  = 1'b1;
            ent_d[wr_idx][wr_way].tag    = wr_tag;
            ent_d[wr_idx][wr_way].target = res_i.target[XLEN-1:OFFSET];
        end else if (do_del && wr_hit) begin
            ent_d[wr_idx][wr_hit_way] = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int r = 0; r < BTB_ROWS; r++) begin
                for (int w = 0; w < WAYS; w++) ent_q[r][w] <= '0;
            end
        end else begin
            ent_q <= ent_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= BTB_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            BTB_IDLE:  if (flush_i) state_d = BTB_SWEEP;
            BTB_SWEEP: begin
                cnt_d = cnt_q + BTB_BITS'(1);
                if (cnt_q == BTB_BITS'(BTB_ROWS - 1)) state_d = BTB_IDLE;
            end
            default:   state_d = BTB_IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state_q == BTB_IDLE);
        sweep   = (state_q == BTB_SWEEP);
    end

    btb_repl #(
        .BTB_BITS (BTB_BITS),
        .WAYS     (WAYS)
    ) u_repl (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .lkp_set_i   (lk_idx),
        .lkp_way_i   (lk_way),
        .lkp_touch_i (hit),
        .wr_set_i    (wr_idx),
        .wr_way_i    (wr_way),
        .wr_touch_i  (do_wr),
        .alloc_i     (alloc),
        .clr_set_i   (sweep),
        .clr_idx_i   (cnt_q),
        .clr_all_i   (1'b0),
        .victim_o    (victim)
    );

    assign unused = ^res_i.target[OFFSET-1:0];

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc: directed vector table, flush and reset
// sequences, then random traffic against a behavioural model.
module tb_btb_assoc;
    import mmm_pkg::*;

    localparam int BB   = 4;
    localparam int W    = 2;
    localparam int ROWS = 16;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        valid_i = 1'b0;
    logic        del_entry_i = 1'b0;
    resolution_t res_i = '0;
    logic        hit_o;
    logic [29:0] target_o;
    logic        ready_o;

    always #5 clk_i = ~clk_i;

    btb_assoc #(.BTB_BITS(BB), .WAYS(W)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .flush_i     (flush_i),
        .pc_i        (pc_i),
        .valid_i     (valid_i),
        .del_entry_i (del_entry_i),
        .res_i       (res_i),
        .hit_o       (hit_o),
        .target_o    (target_o),
        .ready_o     (ready_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic d, input logic f,
                         input logic [31:0] rpc, input logic [31:0] rtgt, input logic [31:0] lpc);
        valid_i = v; del_entry_i = d; flush_i = f;
        res_i.pc = rpc; res_i.target = rtgt; pc_i = lpc;
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    // Behavioural model: per-set list of ways plus replacement bookkeeping.
    bit          m_v   [ROWS][W];
    logic [31:0] m_tag [ROWS][W];
    logic [29:0] m_tgt [ROWS][W];
    int          m_rr  [ROWS];
    int          m_lru [ROWS];
    int          m_busy;

    task automatic m_clear;
        for (int s = 0; s < ROWS; s++) begin
            m_rr[s] = 0; m_lru[s] = 0;
            for (int w = 0; w < W; w++) begin
                m_v[s][w] = 0; m_tag[s][w] = 0; m_tgt[s][w] = 0;
            end
        end
    endtask

    function automatic int m_find(input int s, input logic [31:0] tag);
        for (int w = 0; w < W; w++) if (m_v[s][w] && m_tag[s][w] == tag) return w;
        return -1;
    endfunction

    typedef struct {
        logic        v;
        logic        d;
        logic [31:0] rpc;
        logic [31:0] rtgt;
        logic [31:0] lpc;
        logic        eh;
        logic [29:0] et;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int busy, ls, lw, ws, ww, cyc;
        logic v, d, f, exp_ready, exp_hit;
        logic [31:0] rpc, rtgt, lpc;

        m_clear();
        m_busy = 0;
        repeat (2) @(posedge clk_i);
        #2 rst_n_i = 1'b1;
        step();

`ifndef BTB_PLRU_EN
        tbl.push_back('{1'b0, 1'b0, 32'h0,    32'h0,   32'h40,  1'b0, 30'h0});
        tbl.push_back('{1'b1, 1'b0, 32'h40,   32'h100, 32'h40,  1'b0, 30'h0});
        tbl.push_back('{1'b0, 1'b0, 32'h0,    32'h0,   32'h40,  1'b1, 30'h40});
        tbl.push_back('{1'b1, 1'b0, 32'h440,  32'h300, 32'h440, 1'b0, 30'h40});
        tbl.push_back('{1'b1, 1'b0, 32'h840,  32'h500, 32'h440, 1'b1, 30'hC0});
        tbl.push_back('{1'b0, 1'b0, 32'h0,    32'h0,   32'h40,  1'b0, 30'h140});
        tbl.push_back('{1'b0, 1'b0, 32'h0,    32'h0,   32'h840, 1'b1, 30'h140});
        tbl.push_back('{1'b1, 1'b0, 32'hC40,  32'h600, 32'h440, 1'b1, 30'hC0});
        tbl.push_back('{1'b0, 1'b0, 32'h0,    32'h0,   32'h440, 1'b0, 30'h140});
        tbl.push_back('{1'b1, 1'b0, 32'h44,   32'h100, 32'hC40, 1'b1, 30'h180});
        tbl.push_back('{1'b1, 1'b0, 32'h44,   32'h200, 32'h44,  1'b1, 30'h40});
        tbl.push_back('{1'b0, 1'b0, 32'h0,    32'h0,   32'h44,  1'b1, 30'h80});
        tbl.push_back('{1'b1, 1'b1, 32'h1040, 32'h0,   32'h840, 1'b1, 30'h140});
        tbl.push_back('{1'b1, 1'b1, 32'h44,   32'h0,   32'hC40, 1'b1, 30'h180});
        tbl.push_back('{1'b0, 1'b0, 32'h0,    32'h0,   32'h44,  1'b0, 30'h0});
        tbl.push_back('{1'b0, 1'b0, 32'h0,    32'h0,   32'h840, 1'b1, 30'h140});
        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].d, 1'b0, tbl[i].rpc, tbl[i].rtgt, tbl[i].lpc);
            #1;
            chk($sformatf("vec%0d_ready", i), ready_o, 1'b1);
            chk($sformatf("vec%0d_hit", i), hit_o, tbl[i].eh);
            chk($sformatf("vec%0d_tgt", i), target_o, tbl[i].et);
            step();
        end
`else
        drive(1'b1, 1'b0, 1'b0, 32'h40, 32'h100, 32'h0);  step();
        drive(1'b1, 1'b0, 1'b0, 32'h440, 32'h300, 32'h0); step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h40);    #1;
        chk("plru_hit40", hit_o, 1'b1);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h840, 32'h500, 32'h0); step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h440);   #1;
        chk("plru_evict440", hit_o, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h40);    #1;
        chk("plru_keep40", hit_o, 1'b1);
        chk("plru_tgt40", target_o, 30'h40);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h840);   #1;
        chk("plru_hit840", hit_o, 1'b1);
        step();
`endif

        // Flush sweep: length, forced miss, dropped updates, ignored re-flush.
        drive(1'b1, 1'b0, 1'b0, 32'h3C, 32'h900, 32'h0); step();
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h3C);   #1;
        chk("pre_flush_hit", hit_o, 1'b1);
        chk("pre_flush_tgt", target_o, 30'h240);
        step();
        busy = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            drive(1'b1, 1'b0, (busy == 5), 32'h84, 32'h400, 32'h3C);
            #1;
            if (ready_o) break;
            busy++;
            chk("sweep_hit", hit_o, 1'b0);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h3C);
        chk("flush_len", busy, 16);
        #1 chk("post_flush_3c", hit_o, 1'b0);
        pc_i = 32'h84;  #1 chk("post_flush_84", hit_o, 1'b0);
        pc_i = 32'hC40; #1 chk("post_flush_c40", hit_o, 1'b0);
        step();

        // Reset asserted in the middle of a sweep.
        drive(1'b1, 1'b0, 1'b0, 32'h3C, 32'h900, 32'h0); step();
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h3C);   step();
        flush_i = 1'b0;
        step(); step();
        chk("mid_sweep_ready", ready_o, 1'b0);
        #1 rst_n_i = 1'b0;
        #1;
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_hit", hit_o, 1'b0);
        chk("rst_tgt", target_o, 30'h0);
        #1 rst_n_i = 1'b1;
        step();
        chk("after_rst_hit", hit_o, 1'b0);

        // Random traffic against the model.
        m_clear();
        m_busy = 0;
        for (int c = 0; c < 800; c++) begin
            v   = 1'($urandom_range(0, 1));
            d   = ($urandom_range(0, 3) == 0);
            f   = ($urandom_range(0, 63) == 0);
            rpc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2);
            lpc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2);
            rtgt = $urandom;
            drive(v, d, f, rpc, rtgt, lpc);
            #1;
            exp_ready = (m_busy == 0);
            ls = int'(lpc[5:2]);
            lw = m_find(ls, lpc >> 6);
            exp_hit = exp_ready && (lw >= 0);
            chk("rnd_ready", ready_o, exp_ready);
            chk("rnd_hit", hit_o, exp_hit);
            if (exp_hit) chk("rnd_tgt", target_o, m_tgt[ls][lw]);
            if (m_busy > 0) begin
                m_busy--;
            end else if (f) begin
                m_clear();
                m_busy = 16;
            end else begin
                if (lw >= 0) m_lru[ls] = 1 - lw;
                if (v) begin
                    ws = int'(rpc[5:2]);
                    ww = m_find(ws, rpc >> 6);
                    if (d) begin
                        if (ww >= 0) begin
                            m_v[ws][ww] = 0; m_tag[ws][ww] = 0; m_tgt[ws][ww] = 0;
                        end
                    end else begin
                        if (ww < 0) begin
                            for (int w = W - 1; w >= 0; w--) if (!m_v[ws][w]) ww = w;
                        end
                        if (ww < 0) begin
`ifdef BTB_PLRU_EN
                            ww = m_lru[ws];
`else
                            ww = m_rr[ws];
                            m_rr[ws] = (m_rr[ws] + 1) % W;
`endif
                        end
                        m_v[ws][ww] = 1; m_tag[ws][ww] = rpc >> 6; m_tgt[ws][ww] = rtgt[31:2];
                        m_lru[ws] = 1 - ww;
                    end
                end
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
